cordic_rotation_engine: RTL and testbench
=========================================

// Module: cordic_rotation_engine
// PURPOSE
//  Iterative CORDIC in rotation mode: rotates (x_in,y_in) by angle z_in, driving z toward 0.
//  Complements the vectoring-mode datapath by being its inverse: direction is taken from the sign of z, not y.
//  Supports the CIRCULAR, LINEAR and HYPERBOLIC modes from CONSTANTS.v.
//  Runs one micro-rotation per cycle with a start/busy/done handshake. Sits beside the vectoring core in the CORDIC top.
// PARAMETERS
//  WIDTH      32  datapath width; signed two's complement, Q2.30 for x, y and z (z in radians)
//  ITERATIONS 16  number of distinct shift indices i (the hyperbolic repeats are added on top)
// PORTS
//  clock    in   1      single clock, rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  start    in   1      request; accepted only in IDLE with a valid mode
//  mode     in   2      `CIRCULAR / `LINEAR / `HYPERBOLIC; sampled with start
//  x_in     in   WIDTH  initial x; sampled with start
//  y_in     in   WIDTH  initial y; sampled with start
//  z_in     in   WIDTH  rotation angle (circular, hyperbolic) or multiplier (linear); sampled with start
//  busy     out  1      high from the accept cycle +1 until done
//  done     out  1      one-cycle pulse; outputs valid from this cycle
//  mode_err out  1      one-cycle pulse when start arrives with the undefined 4th mode code
//  x_out    out  WIDTH  final x, held until the next accepted start
//  y_out    out  WIDTH  final y, held until the next accepted start
//  z_out    out  WIDTH  residual z, held until the next accepted start
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - state=IDLE; busy=0; done=0; mode_err=0; x_out/y_out/z_out=0; iteration counter=0.
//   - Reset mid-RUN aborts the operation immediately; no done pulse is produced.
//  State machine
//   - IDLE -> RUN on start with a valid mode: load x, y, z and mode; set i=0 (CIRCULAR, LINEAR) or i=1 (HYPERBOLIC).
//   - RUN: one micro-rotation per cycle; leave RUN after the last iteration.
//   - RUN -> DONE after the last iteration; commit x/y/z to the outputs; done=1.
//   - DONE -> IDLE unconditionally on the next cycle.
//   - start while RUN or DONE is ignored; no queueing.
//  Micro-rotation (per cycle)
//   - d = z[WIDTH-1] ? -1 : +1; z==0 counts as +1.
//   - xs = x>>>i and ys = y>>>i (arithmetic shift). Each update reads the pre-update x, y, z.
//   - CIRCULAR:   x -= d*ys;  y += d*xs;  z -= d*atan(2^-i)
//   - HYPERBOLIC: x += d*ys;  y += d*xs;  z -= d*atanh(2^-i)
//   - LINEAR:     x unchanged; y += d*xs; z -= d*2^-i
//  Iteration count
//   - CIRCULAR, LINEAR: i = 0..ITERATIONS-1, latency ITERATIONS+1 cycles from start to done.
//   - HYPERBOLIC: i = 1..ITERATIONS-1, with i=4 and i=13 each executed twice (13 only if < ITERATIONS).
//     Latency = ITERATIONS+2 cycles at the default.
//  Arithmetic
//   - All sums are modular WIDTH-bit: no saturation, overflow wraps.
//   - No gain compensation: CIRCULAR gain ~1.64676, HYPERBOLIC gain ~0.82816. The caller pre-scales.
//   - Convergence range: circular |z| <= 1.7433; hyperbolic |z| <= 1.1182; linear |z| < 2.
//     Outside these ranges results are unspecified but the FSM still completes.
//  Errors
//   - Undefined mode with start in IDLE: mode_err pulses for 1 cycle, state stays IDLE, outputs unchanged.
// STRUCTURE
//  - CONSTANTS.v (shared): mode codes; `CORDIC_WIDTH; the 1/K circular constant 0x26DD3B6A.
//  - Sub-module cordic_angle_rom (combinational): inputs mode and i; returns atan, atanh or 2^-i in Q2.30.
//    It is shared with the vectoring core.
//  - Remainder: FSM, iteration counter with repeat flag, 3 x WIDTH datapath registers, output registers.
// TESTING (tolerance +/-2^-14 unless stated)
//  - CIRCULAR: x=0x26DD3B6A, y=0, z=0x3243F6A8 (pi/4) -> x_out ~= y_out ~= 0x2D413CCD; |z_out| < 2^-14.
//    done exactly 17 cycles after start.
//  - LINEAR: x=0x20000000 (0.5), y=0, z=0x20000000 -> y_out ~= 0x10000000; x_out == 0x20000000 exactly.
//  - HYPERBOLIC: x=0x40000000, y=0, z=0 -> x_out ~= 0x35000000, y_out ~= 0.
//    done 18 cycles after start, which confirms the i=4 and i=13 repeats.
//  - Handshake: start pulsed during RUN and on the done cycle is ignored, with outputs unchanged.
//    Back-to-back start on the first IDLE cycle is accepted.
//  - Reset: assert reset_n=0 at cycle 5 of RUN -> busy, done, outputs all 0 asynchronously.
//    No done pulse follows; the next start runs normally.
//  - mode=2'b11 (undefined) with start -> mode_err for 1 cycle, busy stays 0, outputs retain prior values.

Source files
------------

// File: rtl/cordic_rotation_engine_pkg.sv
// Shared types and angle tables for the rotation-mode CORDIC engine.
// Angle constants are Q2.30 radians, truncated.
package cordic_rotation_engine_pkg;

    localparam int unsigned CORDIC_WIDTH  = 32;
    localparam logic [31:0] CIRC_INV_GAIN = 32'h26DD3B6A;
    localparam int unsigned ROM_DEPTH     = 16;

    typedef enum logic [1:0] {
        MODE_CIRCULAR   = 2'b00,
        MODE_LINEAR     = 2'b01,
        MODE_HYPERBOLIC = 2'b10,
        MODE_UNDEFINED  = 2'b11
    } cordic_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } cordic_state_e;

    function automatic logic [31:0] atan_q30(input int unsigned i);
        case (i)
            0:       atan_q30 = 32'h3243F6A8;
            1:       atan_q30 = 32'h1DAC6705;
            2:       atan_q30 = 32'h0FADBAFC;
            3:       atan_q30 = 32'h07F56EA6;
            4:       atan_q30 = 32'h03FEAB76;
            5:       atan_q30 = 32'h01FFD55B;
            6:       atan_q30 = 32'h00FFFAAA;
            7:       atan_q30 = 32'h007FFF55;
            8:       atan_q30 = 32'h003FFFEA;
            9:       atan_q30 = 32'h001FFFFD;
            10:      atan_q30 = 32'h000FFFFF;
            11:      atan_q30 = 32'h0007FFFF;
            12:      atan_q30 = 32'h0003FFFF;
            13:      atan_q30 = 32'h0001FFFF;
            14:      atan_q30 = 32'h0000FFFF;
            15:      atan_q30 = 32'h00007FFF;
            default: atan_q30 = 32'h40000000 >> i;
        endcase
    endfunction

    // Index 0 is never issued in hyperbolic mode (atanh(1) is unbounded).
    function automatic logic [31:0] atanh_q30(input int unsigned i);
        case (i)
            0:       atanh_q30 = 32'h00000000;
            1:       atanh_q30 = 32'h2327D4F4;
            2:       atanh_q30 = 32'h1058AEFA;
            3:       atanh_q30 = 32'h080AC48E;
            4:       atanh_q30 = 32'h04015622;
            5:       atanh_q30 = 32'h02002AB1;
            6:       atanh_q30 = 32'h01000555;
            7:       atanh_q30 = 32'h008000AA;
            8:       atanh_q30 = 32'h00400015;
            9:       atanh_q30 = 32'h00200002;
            default: atanh_q30 = 32'h40000000 >> i;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rotation_engine_if.sv
// Start/busy/done handshake and operand/result bus of the rotation engine.
interface cordic_rotation_engine_if
    import cordic_rotation_engine_pkg::*;
#(
    parameter int unsigned WIDTH = CORDIC_WIDTH
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] z_in;
    logic             busy;
    logic             done;
    logic             mode_err;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] z_out;

    modport master (
        output start, mode, x_in, y_in, z_in,
        input  busy, done, mode_err, x_out, y_out, z_out
    );

    modport slave (
        input  start, mode, x_in, y_in, z_in,
        output busy, done, mode_err, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_angle_rom.sv
// Combinational micro-rotation angle: atan(2^-i), atanh(2^-i) or 2^-i in Q2.(WIDTH-2).
// Beyond the table depth atan/atanh are indistinguishable from 2^-i at this precision.
module cordic_angle_rom
    import cordic_rotation_engine_pkg::*;
#(
    parameter int unsigned WIDTH = CORDIC_WIDTH,
    parameter int unsigned IW    = 4
) (
    input  cordic_mode_e             mode,
    input  logic [IW-1:0]            idx,
    output logic signed [WIDTH-1:0]  angle
);

    function automatic logic [WIDTH-1:0] to_q(input logic [31:0] c);
        return WIDTH'({c, 32'h0} >> (64 - WIDTH));
    endfunction

    always_comb begin
        angle = (WIDTH'(1) << (WIDTH - 2)) >> idx;
        if (32'(idx) < ROM_DEPTH) begin
            case (mode)
                MODE_CIRCULAR:   angle = to_q(atan_q30(32'(idx)));
                MODE_HYPERBOLIC: angle = to_q(atanh_q30(32'(idx)));
                default:         ;
            endcase
        end
    end

endmodule

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle, direction from sign of z.
// Circular, linear and hyperbolic modes; hyperbolic repeats i=4 and i=13.
module cordic_rotation_engine
    import cordic_rotation_engine_pkg::*;
#(
    parameter int unsigned WIDTH      = CORDIC_WIDTH,
    parameter int unsigned ITERATIONS = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    cordic_rotation_engine_if.slave   bus
);

    localparam int unsigned   IW       = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ITERATIONS - 1);

    cordic_state_e           state;
    cordic_mode_e            mode_q;
    logic [IW-1:0]           idx;
    logic                    rep;
    logic signed [WIDTH-1:0] x, y, z;
    logic signed [WIDTH-1:0] x_n, y_n, z_n;
    logic signed [WIDTH-1:0] xs, ys, angle;
    logic [WIDTH-1:0]        x_res, y_res, z_res;
    logic                    busy_q, done_q, err_q;
    logic                    neg;
    logic                    repeat_pending;
    logic                    last_iter;

    cordic_angle_rom #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_rom (
        .mode  (mode_q),
        .idx   (idx),
        .angle (angle)
    );

    // A repeated index runs once with rep=0, then again with rep=1 before advancing.
    assign repeat_pending = (mode_q == MODE_HYPERBOLIC) && !rep &&
                            (((ITERATIONS > 4)  && (idx == IW'(4))) ||
                             ((ITERATIONS > 13) && (idx == IW'(13))));
    assign last_iter      = (idx == LAST_IDX) && !repeat_pending;

    always_comb begin
        neg = z[WIDTH-1];
        xs  = x >>> idx;
        ys  = y >>> idx;
        x_n = x;
        y_n = neg ? (y - xs) : (y + xs);
        z_n = neg ? (z + angle) : (z - angle);
        case (mode_q)
            MODE_CIRCULAR:   x_n = neg ? (x + ys) : (x - ys);
            MODE_HYPERBOLIC: x_n = neg ? (x - ys) : (x + ys);
            default:         x_n = x;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_CIRCULAR;
            idx    <= '0;
            rep    <= 1'b0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            x_res  <= '0;
            y_res  <= '0;
            z_res  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (cordic_mode_e'(bus.mode) == MODE_UNDEFINED) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q <= cordic_mode_e'(bus.mode);
                            x      <= bus.x_in;
                            y      <= bus.y_in;
                            z      <= bus.z_in;
                            idx    <= (cordic_mode_e'(bus.mode) == MODE_HYPERBOLIC) ? IW'(1) : '0;
                            rep    <= 1'b0;
                            busy_q <= 1'b1;
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    if (last_iter) begin
                        x_res  <= x_n;
                        y_res  <= y_n;
                        z_res  <= z_n;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (repeat_pending) begin
                        rep <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                        rep <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mode_err = err_q;
    assign bus.x_out    = x_res;
    assign bus.y_out    = y_res;
    assign bus.z_out    = z_res;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Randomized bench for cordic_rotation_engine against a closed-form real-valued model
// (rotation by z with the accumulated CORDIC gain), plus literal reference points.
module tb_cordic_rotation_engine;
    import cordic_rotation_engine_pkg::*;

    localparam real SCALE = 1073741824.0;
    localparam real TOL   = 1.0 / 16384.0;

    typedef struct {
        real         x;
        real         y;
        bit          lin;
        logic [31:0] xb;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur;

    cordic_rotation_engine_if #(.WIDTH(32)) bus();

    cordic_rotation_engine #(
        .WIDTH      (32),
        .ITERATIONS (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic real q2r(input logic [31:0] v);
        return $itor($signed(v)) / SCALE;
    endfunction

    function automatic real gain(input bit hyp);
        real k;
        real p;
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < 16; i++) begin
            if (!hyp) begin
                k = k * $sqrt(1.0 + p);
            end else if (i > 0) begin
                k = k * $sqrt(1.0 - p);
                if (i == 4 || i == 13) k = k * $sqrt(1.0 - p);
            end
            p = p / 4.0;
        end
        return k;
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic [31:0] xi,
                                   input logic [31:0] yi, input logic [31:0] zi);
        exp_t e;
        real  x, y, z, k;
        x = q2r(xi);
        y = q2r(yi);
        z = q2r(zi);
        e.lin = 1'b0;
        e.xb  = xi;
        case (m)
            2'b00: begin
                k   = gain(1'b0);
                e.x = k * (x * $cos(z) - y * $sin(z));
                e.y = k * (y * $cos(z) + x * $sin(z));
            end
            2'b01: begin
                e.x   = x;
                e.y   = y + x * z;
                e.lin = 1'b1;
            end
            2'b10: begin
                k   = gain(1'b1);
                e.x = k * (x * $cosh(z) + y * $sinh(z));
                e.y = k * (y * $cosh(z) + x * $sinh(z));
            end
            default: begin
                e.x = x;
                e.y = y;
            end
        endcase
        return e;
    endfunction

    task automatic chk_bits(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_tol(input string name, input logic [31:0] act, input real req);
        real d;
        d = q2r(act) - req;
        if (d < 0.0) d = -d;
        checks++;
        if (d > TOL) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (+/-2^-14)", name, act, 32'($rtoi(req * SCALE)));
        end
    endtask

    function automatic logic [31:0] rnd(input int unsigned span);
        return 32'($urandom_range(0, span)) - 32'(span >> 1);
    endfunction

    // Outputs must track the most recent completed operation on every cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            chk_tol("x_out", bus.x_out, cur.x);
            chk_tol("y_out", bus.y_out, cur.y);
            chk_tol("z_out", bus.z_out, 0.0);
            if (cur.lin) chk_bits("x_out_linear_exact", bus.x_out, cur.xb);
        end
    end

    task automatic run_op(input logic [1:0] m, input logic [31:0] xi, input logic [31:0] yi,
                          input logic [31:0] zi, input bit poke);
        int lat;
        int exp_lat;
        exp_lat = (m == 2'b10) ? 18 : 17;
        @(negedge clock);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.x_in  = xi;
        bus.y_in  = yi;
        bus.z_in  = zi;
        @(negedge clock);
        bus.start = 1'b0;
        exp_q.push_back(model(m, xi, yi, zi));
        lat = 1;
        chk_bits("busy_after_accept", 32'(bus.busy), 32'd1);
        while (!bus.done && lat < 60) begin
            if (poke && lat == 5) begin
                bus.start = 1'b1;
                bus.mode  = 2'b01;
                bus.x_in  = $urandom;
                bus.z_in  = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        bus.start = 1'b0;
        chk_bits("latency", 32'(lat), 32'(exp_lat));
        chk_bits("busy_at_done", 32'(bus.busy), 32'd0);
        if (poke) begin
            bus.start = 1'b1;
            bus.mode  = 2'b00;
            bus.x_in  = $urandom;
            bus.y_in  = $urandom;
            @(negedge clock);
            bus.start = 1'b0;
            chk_bits("start_on_done_ignored_busy", 32'(bus.busy), 32'd0);
            chk_bits("done_single_pulse", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  m;
        logic [31:0] xr, yr, zr;
        cur.x     = 0.0;
        cur.y     = 0.0;
        cur.lin   = 1'b0;
        cur.xb    = '0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.x_in  = '0;
        bus.y_in  = '0;
        bus.z_in  = '0;
        repeat (2) @(negedge clock);
        chk_bits("reset_busy", 32'(bus.busy), 32'd0);
        chk_bits("reset_done", 32'(bus.done), 32'd0);
        chk_bits("reset_mode_err", 32'(bus.mode_err), 32'd0);
        chk_bits("reset_x_out", bus.x_out, 32'd0);
        chk_bits("reset_y_out", bus.y_out, 32'd0);
        chk_bits("reset_z_out", bus.z_out, 32'd0);
        #2 reset_n = 1'b1;

        run_op(2'b00, CIRC_INV_GAIN, 32'h0, 32'h3243F6A8, 1'b0);
        chk_tol("circ_pi4_x", bus.x_out, q2r(32'h2D413CCD));
        chk_tol("circ_pi4_y", bus.y_out, q2r(32'h2D413CCD));
        chk_tol("circ_pi4_z", bus.z_out, 0.0);

        run_op(2'b01, 32'h20000000, 32'h0, 32'h20000000, 1'b0);
        chk_tol("lin_y", bus.y_out, q2r(32'h10000000));
        chk_bits("lin_x_exact", bus.x_out, 32'h20000000);

        run_op(2'b10, 32'h40000000, 32'h0, 32'h0, 1'b0);
        chk_tol("hyp_x", bus.x_out, q2r(32'h35000000));
        chk_tol("hyp_y", bus.y_out, 0.0);

        @(negedge clock);
        bus.start = 1'b1;
        bus.mode  = 2'b11;
        bus.x_in  = $urandom;
        bus.y_in  = $urandom;
        bus.z_in  = $urandom;
        @(negedge clock);
        bus.start = 1'b0;
        chk_bits("mode_err_pulse", 32'(bus.mode_err), 32'd1);
        chk_bits("mode_err_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        chk_bits("mode_err_one_cycle", 32'(bus.mode_err), 32'd0);
        chk_bits("mode_err_no_run", 32'(bus.busy), 32'd0);

        run_op(2'b00, rnd(32'h3000_0000), rnd(32'h3000_0000), rnd(32'hC000_0000), 1'b1);

        // Abort mid-run: everything clears at once and no completion follows.
        @(negedge clock);
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        bus.x_in  = rnd(32'h3000_0000);
        bus.y_in  = rnd(32'h3000_0000);
        bus.z_in  = rnd(32'hC000_0000);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        cur.x   = 0.0;
        cur.y   = 0.0;
        cur.lin = 1'b0;
        chk_bits("abort_busy", 32'(bus.busy), 32'd0);
        chk_bits("abort_done", 32'(bus.done), 32'd0);
        chk_bits("abort_x_out", bus.x_out, 32'd0);
        chk_bits("abort_y_out", bus.y_out, 32'd0);
        chk_bits("abort_z_out", bus.z_out, 32'd0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (25) @(negedge clock);
        chk_bits("abort_still_idle", 32'(bus.busy), 32'd0);

        for (int n = 0; n < 36; n++) begin
            m  = 2'($urandom_range(0, 2));
            xr = rnd(32'h3000_0000);
            yr = rnd(32'h3000_0000);
            zr = (m == 2'b10) ? rnd(32'h8000_0000) : rnd(32'hC000_0000);
            run_op(m, xr, yr, zr, (n % 9) == 0);
        end
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
